// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and big-endian lane helpers for load_store_unit.
//   SZ_*          req_size encodings (byte/half/word/illegal)
//   lsu_state_e   sequencer states
//   lane_extract  pick a byte/half lane out of a memory word and extend it
//   lane_merge    replace a byte/half lane of a memory word with store data
// Lane numbering is big-endian: byte offset 0 is word[31:24].
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD     = 3'd1,
    ST     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } lsu_state_e;

  // off must already be lane-aligned for the access size.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    unique case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    unique case (size)
      SZ_BYTE: lane_extract = {{24{sgn & b[7]}}, b};
      SZ_HALF: lane_extract = {{16{sgn & h[15]}}, h};
      default: lane_extract = word;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    unique case (size)
      SZ_BYTE: begin
        unique case (off)
          2'd0:    r[31:24] = data[7:0];
          2'd1:    r[23:16] = data[7:0];
          2'd2:    r[15:8]  = data[7:0];
          default: r[7:0]   = data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) r[15:0]  = data[15:0];
        else        r[31:16] = data[15:0];
      end
      default: r = data;
    endcase
    lane_merge = r;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: combinational lane extract (loads) and lane merge (RMW stores).
//   ext_word_i    raw memory word for a load
//   merge_word_i  word captured during the RMW read
//   merge_data_i  right-justified store data
//   off_i         lane-aligned byte offset
//   size_i        access size (SZ_*)
//   sgn_i         sign-extend loaded lane
//   ext_o         extended load result
//   merge_o       word with target lane replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] ext_word_i,
  input  logic [31:0] merge_word_i,
  input  logic [31:0] merge_data_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  output logic [31:0] ext_o,
  output logic [31:0] merge_o
);

  assign ext_o   = lane_extract(ext_word_i, off_i, size_i, sgn_i);
  assign merge_o = lane_merge(merge_word_i, merge_data_i, off_i, size_i);

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage sequencer in front of a big-endian, word-wide data memory.
// One request at a time; sub-word stores are done as read-modify-write.
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_wr/size/signed/addr/wdata   request fields, latched on accept
//   resp_valid/rdata/err      one-cycle completion pulse with load data / error
//   mem_addr/wr_data/wr/rd    word-aligned memory access, strobes mutually exclusive
//   mem_rd_data               combinational read word from memory
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses;
// otherwise the low address bits are masked and the access proceeds.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rd_data
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("load_store_unit: DATA_W must be 32");
  end

  lsu_state_e        state_q, state_d;
  logic              wr_q, sgn_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_q;   // extended load result, or raw word during RMW

  logic              accept, req_ill, req_mis, req_fault;
  logic [1:0]        lane_off;
  logic [DATA_W-1:0] ext_word, merged_word;

  assign accept  = req_valid && (state_q == IDLE);
  assign req_ill = (req_size == SZ_ILL);
  assign req_mis = ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

`ifdef MISALIGN_TRAP_EN
  assign req_fault = req_ill || req_mis;
`else
  assign req_fault = req_ill;
`endif

  // Masking the low bits here is what makes untrapped misaligned accesses
  // land on the naturally aligned lane.
  always_comb begin
    unique case (size_q)
      SZ_HALF: lane_off = {addr_q[1], 1'b0};
      SZ_WORD: lane_off = 2'b00;
      default: lane_off = addr_q[1:0];
    endcase
  end

  lsu_lane_align u_align (
    .ext_word_i   (mem_rd_data),
    .merge_word_i (data_q),
    .merge_data_i (wdata_q),
    .off_i        (lane_off),
    .size_i       (size_q),
    .sgn_i        (sgn_q),
    .ext_o        (ext_word),
    .merge_o      (merged_word)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_fault)                state_d = RESP;
          else if (!req_wr)             state_d = LD;
          else if (req_size == SZ_WORD) state_d = ST;
          else                          state_d = RMW_RD;
        end
      end
      LD:      state_d = RESP;
      ST:      state_d = RESP;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields and captured data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        wr_q    <= req_wr;
        sgn_q   <= req_signed;
        err_q   <= req_fault;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == LD)          data_q <= ext_word;
      else if (state_q == RMW_RD) data_q <= mem_rd_data;
    end
  end

  // Outputs: everything is 0 outside the states that own it, so an async
  // reset clears all outputs in the same instant.
  always_comb begin
    req_ready   = (state_q == IDLE);
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_wr_data = '0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = '0;
    unique case (state_q)
      LD, RMW_RD: mem_rd = 1'b1;
      ST: begin
        mem_wr      = 1'b1;
        mem_wr_data = wdata_q;
      end
      RMW_WR: begin
        mem_wr      = 1'b1;
        mem_wr_data = merged_word;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        // data_q holds the raw RMW word after a store; only loads report it
        if (!wr_q && !err_q) resp_rdata = data_q;
      end
      default: ;
    endcase
    mem_addr = (mem_rd || mem_wr) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int AW   = 32;
  localparam int MEMB = 64;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_wr = 1'b0, req_signed = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid, resp_err, mem_wr, mem_rd;
  logic [31:0]   resp_rdata, mem_wr_data, mem_rd_data;
  logic [AW-1:0] mem_addr;

  load_store_unit #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT (big-endian bytes) and the model's own copy.
  logic [7:0] dmem  [MEMB];
  logic [7:0] ref_b [MEMB];
  logic [5:0] ma;
  assign ma = {mem_addr[5:2], 2'b00};
  assign mem_rd_data = {dmem[ma], dmem[ma+6'd1], dmem[ma+6'd2], dmem[ma+6'd3]};
  always @(posedge clk) if (mem_wr) begin
    dmem[ma]      <= mem_wr_data[31:24];
    dmem[ma+6'd1] <= mem_wr_data[23:16];
    dmem[ma+6'd2] <= mem_wr_data[15:8];
    dmem[ma+6'd3] <= mem_wr_data[7:0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  a_excl: assert property (@(posedge clk) disable iff (rst) !(mem_rd && mem_wr));

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected schedule for the request in flight, in negedge-sampled cycles.
  int          s_n = -100, s_lat = 0, s_rd = -1, s_wr = -1;
  logic [31:0] s_rdata = '0, s_wdata = '0, s_addr = '0;
  logic        s_err = 1'b0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  bit          chk_en = 1'b0;

  // Behavioural model: byte-array arithmetic, issued at the cycle the request is driven.
  task automatic model_req(input bit wr, input bit [1:0] sz, input bit sg,
                           input bit [31:0] a, input bit [31:0] wd);
    int nb, ea, wa;
    bit mis;
    longint v, lim;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'b00));
    wa  = int'(a) & ~3;
    s_n = cyc; s_rd = -1; s_wr = -1; s_rdata = '0; s_wdata = '0; s_err = 1'b0;
    s_addr = 32'(wa);
    if (sz == 2'd3 || (TRAP && mis)) begin
      s_err = 1'b1; s_lat = 1;
      return;
    end
    ea = int'(a) & ~(nb - 1);
    if (!wr) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v * 256 + longint'(ref_b[ea+i]);
      lim = longint'(1) << (8 * nb);
      if (sg && v >= lim / 2) v = v - lim;
      s_rdata = v[31:0];
      s_lat = 2; s_rd = s_n + 1;
    end else begin
      for (int i = 0; i < nb; i++) ref_b[ea+i] = 8'(wd >> (8 * (nb - 1 - i)));
      s_wdata = {ref_b[wa], ref_b[wa+1], ref_b[wa+2], ref_b[wa+3]};
      if (nb == 4) begin s_lat = 2; s_wr = s_n + 1; end
      else begin s_lat = 3; s_rd = s_n + 1; s_wr = s_n + 2; end
    end
  endtask

  // Single compare process: every cycle, every output that has a defined value.
  always @(negedge clk) if (chk_en) begin
    bit busy;
    busy = (cyc > s_n) && (cyc <= s_n + s_lat);
    chk("strobe_excl", {31'b0, mem_rd & mem_wr}, 32'd0);
    chk("req_ready",   {31'b0, req_ready},  {31'b0, !busy});
    chk("mem_rd",      {31'b0, mem_rd},     {31'b0, cyc == s_rd});
    chk("mem_wr",      {31'b0, mem_wr},     {31'b0, cyc == s_wr});
    chk("resp_valid",  {31'b0, resp_valid}, {31'b0, cyc == s_n + s_lat});
    if (cyc == s_rd || cyc == s_wr) chk("mem_addr", mem_addr, s_addr);
    if (cyc == s_wr) chk("mem_wr_data", mem_wr_data, s_wdata);
    if (cyc == s_n + s_lat) begin
      chk("resp_rdata", resp_rdata, s_rdata);
      chk("resp_err", {31'b0, resp_err}, {31'b0, s_err});
      last_rdata = resp_rdata;
      last_err   = resp_err;
    end
  end

  task automatic do_req(input bit wr, input bit [1:0] sz, input bit sg,
                        input bit [31:0] a, input bit [31:0] wd,
                        output logic [31:0] rd, output logic er);
    @(negedge clk);
    model_req(wr, sz, sg, a, wd);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    // While busy, wiggle the request lines; none of it may be accepted.
    for (int k = 0; k < s_lat; k++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_wr    = 1'($urandom_range(0, 1));
      req_size  = 2'($urandom_range(0, 3));
      req_addr  = 32'($urandom_range(0, MEMB - 1));
      req_wdata = $urandom;
    end
    #1;
    rd = last_rdata;
    er = last_err;
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic [7:0]  saved [MEMB];
    logic [7:0]  pre [8];
    pre = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h80, 8'h7F, 8'h00, 8'h01};
    for (int i = 0; i < MEMB; i++) dmem[i] = (i < 8) ? pre[i] : 8'($urandom);
    ref_b = dmem;

    repeat (2) @(negedge clk);
    chk("rst_resp_valid",  {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err",    {31'b0, resp_err},   32'd0);
    chk("rst_mem_rd",      {31'b0, mem_rd},     32'd0);
    chk("rst_mem_wr",      {31'b0, mem_wr},     32'd0);
    chk("rst_resp_rdata",  resp_rdata,  32'd0);
    chk("rst_mem_addr",    mem_addr,    32'd0);
    chk("rst_mem_wr_data", mem_wr_data, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle();
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Hand-computed expectations pinning the model
    do_req(0, 2'd2, 0, 0, 0, r, e); chk("lw0", r, 32'h11223344); chk("lw0_err", {31'b0, e}, 0);
    do_req(0, 2'd0, 1, 4, 0, r, e); chk("lb4", r, 32'hFFFFFF80);
    do_req(0, 2'd0, 0, 4, 0, r, e); chk("lbu4", r, 32'h00000080);
    do_req(0, 2'd1, 1, 4, 0, r, e); chk("lh4", r, 32'hFFFF807F);
    do_req(0, 2'd1, 0, 6, 0, r, e); chk("lhu6", r, 32'h00000001);
    do_req(0, 2'd2, 0, 2, 0, r, e);
    if (TRAP) begin
      chk("lw2_trap_err", {31'b0, e}, 32'd1); chk("lw2_trap_data", r, 32'd0);
    end else begin
      chk("lw2_mask_err", {31'b0, e}, 32'd0); chk("lw2_mask_data", r, 32'h11223344);
    end
    do_req(1, 2'd0, 0, 1, 32'hAB, r, e); chk("sb1_rdata", r, 32'd0);
    do_req(0, 2'd2, 0, 0, 0, r, e);      chk("lw0_after_sb", r, 32'h11AB3344);
    do_req(1, 2'd0, 0, 1, 32'h22, r, e);
    do_req(1, 2'd1, 0, 2, 32'hBEEF, r, e);
    do_req(0, 2'd2, 0, 0, 0, r, e);      chk("lw0_after_sh", r, 32'h1122BEEF);
    do_req(0, 2'd3, 0, 8, 0, r, e);      chk("ill_ld_err", {31'b0, e}, 32'd1);
    chk("ill_ld_data", r, 32'd0);
    do_req(1, 2'd3, 0, 8, 32'h5A, r, e); chk("ill_st_err", {31'b0, e}, 32'd1);

    // Reset in the middle of a sub-word store's read phase
    saved = ref_b;
    @(negedge clk);
    model_req(1, 2'd0, 0, 1, 32'hCD);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd1; req_wdata = 32'hCD;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst = 1'b1;
    s_n = -100; s_lat = 0; s_rd = -1; s_wr = -1;
    #1;
    chk("mid_rst_mem_rd",     {31'b0, mem_rd},     32'd0);
    chk("mid_rst_mem_wr",     {31'b0, mem_wr},     32'd0);
    chk("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("mid_rst_mem_addr",   mem_addr, 32'd0);
    ref_b = saved;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_req(0, 2'd2, 0, 0, 0, r, e); chk("lw0_after_rst", r, 32'h1122BEEF);

    // Randomized traffic against the model
    for (int t = 0; t < 400; t++) begin
      bit [1:0] sz;
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             32'($urandom_range(0, MEMB - 1)), $urandom, r, e);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    idle();

    for (int w = 0; w < MEMB; w += 4)
      chk("final_mem", {dmem[w], dmem[w+1], dmem[w+2], dmem[w+3]},
                       {ref_b[w], ref_b[w+1], ref_b[w+2], ref_b[w+3]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
